// File: rtl/stage_platforms.sv
// rtl/stage_platforms.sv - per-stage platform table with ROM reload, bar motion and registered hit query
module stage_platforms #(
  parameter int N_BARS     = 4,
  parameter int COORD_W    = 10,
  parameter int STAGE_W    = 2,
  parameter int STEP       = 2,
  parameter int MOVE_RANGE = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [STAGE_W-1:0]            stage_number,
  input  logic                          frame_tick,
  input  logic [COORD_W-1:0]            pix_x,
  input  logic [COORD_W-1:0]            pix_y,
  output logic                          ready,
  output logic                          bar_hit,
  output logic [((N_BARS > 1) ? $clog2(N_BARS) : 1)-1:0] bar_idx,
  output logic [N_BARS*4*COORD_W-1:0]   bars_flat
);

  localparam int IW = (N_BARS > 1) ? $clog2(N_BARS) : 1;

  typedef struct packed {
    logic [COORD_W-1:0] hm;
    logic [COORD_W-1:0] he;
    logic [COORD_W-1:0] vm;
    logic [COORD_W-1:0] ve;
    logic               mv;
  } rom_t;

  typedef enum logic {LOAD, READY} state_t;

  function automatic rom_t mk(input int hm, input int he, input int vm, input int ve, input logic mv);
    rom_t r;
    r.hm = COORD_W'(hm);
    r.he = COORD_W'(he);
    r.vm = COORD_W'(vm);
    r.ve = COORD_W'(ve);
    r.mv = mv;
    return r;
  endfunction

  // Stage ROM; stages 2 and above share one layout, slots past 3 are empty.
  function automatic rom_t rom_lookup(input logic [STAGE_W-1:0] stg, input int idx);
    rom_t r;
    r = mk(0, 0, 0, 0, 1'b0);
    if (stg == '0) begin
      case (idx)
        0: r = mk(100, 250, 350, 375, 1'b0);
        1: r = mk(350, 500, 350, 375, 1'b0);
        2: r = mk( 10,  40, 170, 195, 1'b0);
        3: r = mk(250, 300,  70,  95, 1'b1);
        default: r = mk(0, 0, 0, 0, 1'b0);
      endcase
    end else if (stg == STAGE_W'(1)) begin
      case (idx)
        0: r = mk(  0, 130, 360, 480, 1'b0);
        1: r = mk(160, 290, 240, 360, 1'b1);
        2: r = mk(320, 450, 120, 240, 1'b0);
        3: r = mk(480, 610,   0, 120, 1'b0);
        default: r = mk(0, 0, 0, 0, 1'b0);
      endcase
    end else begin
      case (idx)
        0: r = mk(  0, 150, 190, 450, 1'b0);
        1: r = mk(150, 250, 260, 450, 1'b0);
        2: r = mk(250, 470, 350, 450, 1'b0);
        3: r = mk(460, 520, 300, 450, 1'b0);
        default: r = mk(0, 0, 0, 0, 1'b0);
      endcase
    end
    return r;
  endfunction

  state_t               state;
  logic [STAGE_W-1:0]   stage_latched;
  logic [IW-1:0]        load_idx;
  logic [COORD_W-1:0]   base_hm [N_BARS];
  logic [COORD_W-1:0]   base_he [N_BARS];
  logic [COORD_W-1:0]   v_m     [N_BARS];
  logic [COORD_W-1:0]   v_e     [N_BARS];
  logic [COORD_W-1:0]   offset  [N_BARS];
  logic                 moving  [N_BARS];
  logic                 dir_left[N_BARS];

  logic [COORD_W-1:0]   h_m     [N_BARS];
  logic [COORD_W-1:0]   h_e     [N_BARS];
  logic [COORD_W:0]     step_up [N_BARS];
  logic [COORD_W-1:0]   nxt_off [N_BARS];
  logic                 nxt_dir [N_BARS];
  rom_t                 load_entry;
  logic                 hit_any;
  logic [IW-1:0]        hit_idx;

  assign load_entry = rom_lookup(stage_latched, int'(load_idx));

  // Live rectangles and flat export: ROM position shifted by the motion offset.
  for (genvar g = 0; g < N_BARS; g++) begin : g_bar
    assign h_m[g] = base_hm[g] + offset[g];
    assign h_e[g] = base_he[g] + offset[g];
    assign bars_flat[g*4*COORD_W +: 4*COORD_W] = {v_e[g], v_m[g], h_e[g], h_m[g]};
  end

  // Next offset/direction for each bar on a frame tick, bouncing between 0 and MOVE_RANGE.
  always_comb begin
    for (int i = 0; i < N_BARS; i++) begin
      step_up[i] = {1'b0, offset[i]} + (COORD_W+1)'(STEP);
      nxt_off[i] = offset[i];
      nxt_dir[i] = dir_left[i];
      if (!dir_left[i]) begin
        if (step_up[i] >= (COORD_W+1)'(MOVE_RANGE)) begin
          nxt_off[i] = COORD_W'(MOVE_RANGE);
          nxt_dir[i] = 1'b1;
        end else begin
          nxt_off[i] = step_up[i][COORD_W-1:0];
        end
      end else begin
        if (offset[i] <= COORD_W'(STEP)) begin
          nxt_off[i] = '0;
          nxt_dir[i] = 1'b0;
        end else begin
          nxt_off[i] = offset[i] - COORD_W'(STEP);
        end
      end
    end
  end

  // Lowest-index bar containing the query pixel; iterate downward so the lowest wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = N_BARS - 1; i >= 0; i--) begin
      if (pix_x >= h_m[i] && pix_x < h_e[i] && pix_y >= v_m[i] && pix_y < v_e[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Load/ready FSM: stage changes restart the ROM load, motion only while the table is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD;
      ready         <= 1'b0;
      stage_latched <= '0;
      load_idx      <= '0;
      for (int i = 0; i < N_BARS; i++) begin
        base_hm[i]  <= '0;
        base_he[i]  <= '0;
        v_m[i]      <= '0;
        v_e[i]      <= '0;
        offset[i]   <= '0;
        moving[i]   <= 1'b0;
        dir_left[i] <= 1'b0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (stage_number != stage_latched) begin
            stage_latched <= stage_number;
            load_idx      <= '0;
          end else begin
            for (int i = 0; i < N_BARS; i++) begin
              if (load_idx == IW'(i)) begin
                base_hm[i]  <= load_entry.hm;
                base_he[i]  <= load_entry.he;
                v_m[i]      <= load_entry.vm;
                v_e[i]      <= load_entry.ve;
                moving[i]   <= load_entry.mv;
                offset[i]   <= '0;
                dir_left[i] <= 1'b0;
              end
            end
            if (load_idx == IW'(N_BARS - 1)) begin
              state <= READY;
              ready <= 1'b1;
            end else begin
              load_idx <= load_idx + 1'b1;
            end
          end
        end
        READY: begin
          if (stage_number != stage_latched) begin
            stage_latched <= stage_number;
            load_idx      <= '0;
            state         <= LOAD;
            ready         <= 1'b0;
          end else if (frame_tick) begin
            for (int i = 0; i < N_BARS; i++) begin
              if (moving[i]) begin
                offset[i]   <= nxt_off[i];
                dir_left[i] <= nxt_dir[i];
              end
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Registered hit query, suppressed until the table is fully loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_hit <= 1'b0;
      bar_idx <= '0;
    end else begin
      bar_hit <= ready && hit_any;
      bar_idx <= (ready && hit_any) ? hit_idx : '0;
    end
  end

endmodule
